sim_bus_arb: RTL and testbench



---
 rtl/sim_bus_arb.sv | 185 ++++++++++++++++++
 tb/tb_sim_bus_arb.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_bus_arb.sv
// Single-outstanding host/device bus for simulation tops: fixed or round-robin
// arbitration, address decode with error response, and a device response timeout.
module sim_bus_arb #(
    parameter int unsigned NrHosts       = 3,
    parameter int unsigned NrDevices     = 2,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddressWidth  = 32,
    parameter bit          RoundRobin    = 1'b0,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NrHosts-1:0]        host_req_i,
    input  logic [NrHosts-1:0]        host_we_i,
    input  logic [DataWidth/8-1:0]    host_be_i            [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i          [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i         [NrHosts],
    output logic [NrHosts-1:0]        host_gnt_o,
    output logic [NrHosts-1:0]        host_rvalid_o,
    output logic [NrHosts-1:0]        host_err_o,
    output logic [DataWidth-1:0]      host_rdata_o         [NrHosts],
    output logic [NrDevices-1:0]      device_req_o,
    output logic [NrDevices-1:0]      device_we_o,
    output logic [DataWidth/8-1:0]    device_be_o          [NrDevices],
    output logic [AddressWidth-1:0]   device_addr_o        [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o       [NrDevices],
    input  logic [NrDevices-1:0]      device_rvalid_i,
    input  logic [NrDevices-1:0]      device_err_i,
    input  logic [DataWidth-1:0]      device_rdata_i       [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices],
    output logic                      timeout_o,
    output logic                      stray_o
);

    localparam int unsigned HW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int unsigned DW = (NrDevices > 1) ? $clog2(NrDevices) : 1;
    localparam int unsigned CW = $clog2(TimeoutCycles);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DERR
    } state_e;

    state_e                  state_q, state_d;
    logic [HW-1:0]           owner_q, owner_d;
    logic [HW-1:0]           ptr_q, ptr_d;
    logic [DW-1:0]           dev_q, dev_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [HW-1:0]           win;
    logic [DW-1:0]           hit_dev;
    logic [AddressWidth-1:0] win_addr;
    logic                    req_any;
    logic                    hit;
    logic                    owed_rvalid;
    logic                    timeout_hit;
    logic                    accept;
    logic                    gnt;
    int unsigned             idx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            dev_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            dev_q   <= dev_d;
            cnt_q   <= cnt_d;
        end
    end

    // A new grant is only possible once the owed response is here.
    always_comb begin
        owed_rvalid = (state_q == WAIT) && device_rvalid_i[dev_q];
        timeout_hit = (state_q == WAIT) && !owed_rvalid
                      && (cnt_q == CW'(TimeoutCycles - 1));
        accept      = !rst_i && ((state_q != WAIT) || owed_rvalid);
    end

    always_comb begin
        req_any = 1'b0;
        win     = '0;
        idx     = 0;
        for (int unsigned i = 0; i < NrHosts; i++) begin
            idx = RoundRobin ? (32'(ptr_q) + i) % NrHosts : i;
            if (!req_any && host_req_i[idx]) begin
                req_any = 1'b1;
                win     = HW'(idx);
            end
        end
        win_addr = host_addr_i[win];
        hit      = 1'b0;
        hit_dev  = '0;
        for (int d = int'(NrDevices) - 1; d >= 0; d--) begin
            if ((win_addr & cfg_device_addr_mask[d])
                == cfg_device_addr_base[d]) begin
                hit     = 1'b1;
                hit_dev = DW'(d);
            end
        end
        gnt = accept && req_any;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        dev_d   = dev_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WAIT: begin
                if (owed_rvalid || timeout_hit) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DERR:    state_d = IDLE;
            default: state_d = state_q;
        endcase
        if (gnt) begin
            owner_d = win;
            ptr_d   = (win == HW'(NrHosts - 1)) ? '0 : win + 1'b1;
            if (hit) begin
                state_d = WAIT;
                dev_d   = hit_dev;
                cnt_d   = '0;
            end else begin
                state_d = DERR;
            end
        end
    end

    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        device_req_o  = '0;
        device_we_o   = '0;
        timeout_o     = 1'b0;
        stray_o       = 1'b0;
        for (int h = 0; h < int'(NrHosts); h++) begin
            host_rdata_o[h] = '0;
        end
        for (int d = 0; d < int'(NrDevices); d++) begin
            device_be_o[d]    = '0;
            device_addr_o[d]  = '0;
            device_wdata_o[d] = '0;
        end
        if (!rst_i) begin
            for (int d = 0; d < int'(NrDevices); d++) begin
                if (device_rvalid_i[d]
                    && !((state_q == WAIT) && (DW'(d) == dev_q))) begin
                    stray_o = 1'b1;
                end
            end
            if (owed_rvalid) begin
                host_rvalid_o[owner_q] = 1'b1;
                host_err_o[owner_q]    = device_err_i[dev_q];
                host_rdata_o[owner_q]  = device_rdata_i[dev_q];
            end else if (timeout_hit || (state_q == DERR)) begin
                host_rvalid_o[owner_q] = 1'b1;
                host_err_o[owner_q]    = 1'b1;
                timeout_o              = timeout_hit;
            end
            if (gnt) begin
                host_gnt_o[win] = 1'b1;
                if (hit) begin
                    device_req_o[hit_dev]   = 1'b1;
                    device_we_o[hit_dev]    = host_we_i[win];
                    device_be_o[hit_dev]    = host_be_i[win];
                    device_addr_o[hit_dev]  = win_addr;
                    device_wdata_o[hit_dev] = host_wdata_i[win];
                end
            end
        end
    end

endmodule

// File: tb/tb_sim_bus_arb.sv
// Drives a fixed-priority and a round-robin bus with identical host traffic
// and compares both against a transaction-level model every cycle.
module tb_sim_bus_arb;

    localparam int NH = 3;
    localparam int ND = 2;
    localparam int TO = 16;

    typedef struct packed {
        logic [NH-1:0]        gnt;
        logic [NH-1:0]        rv;
        logic [NH-1:0]        er;
        logic [NH-1:0][31:0]  rd;
        logic [ND-1:0]        dreq;
        logic [ND-1:0]        dwe;
        logic [ND-1:0][3:0]   dbe;
        logic [ND-1:0][31:0]  dad;
        logic [ND-1:0][31:0]  dwd;
        logic                 to;
        logic                 st;
    } snap_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NH-1:0] hreq, hwe;
    logic [3:0]    hbe   [NH];
    logic [31:0]   haddr [NH];
    logic [31:0]   hwd   [NH];
    logic [31:0]   cbase [ND];
    logic [31:0]   cmask [ND];

    logic [NH-1:0] gnt_f, rv_f, er_f, gnt_r, rv_r, er_r;
    logic [31:0]   rd_f [NH];
    logic [31:0]   rd_r [NH];
    logic [ND-1:0] dreq_f, dwe_f, dreq_r, dwe_r;
    logic [3:0]    dbe_f [ND];
    logic [3:0]    dbe_r [ND];
    logic [31:0]   dad_f [ND];
    logic [31:0]   dad_r [ND];
    logic [31:0]   dwd_f [ND];
    logic [31:0]   dwd_r [ND];
    logic          to_f, st_f, to_r, st_r;
    logic [ND-1:0] drv_f, drv_r, der_f, der_r;
    logic [31:0]   drd_f [ND];
    logic [31:0]   drd_r [ND];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int    busy [2];
    int    own  [2];
    int    dv   [2];
    int    age  [2];
    int    rrp  [2];
    bit    m_gnt  [2];
    bit    m_done [2];
    int    m_win  [2];
    int    m_tgt  [2];
    bit    pend_rv [2];
    logic [31:0] pend_rd [2];
    logic [31:0] ram [2][256];
    snap_t last [2];

    sim_bus_arb #(
        .NrHosts(NH), .NrDevices(ND), .DataWidth(32), .AddressWidth(32),
        .RoundRobin(1'b0), .TimeoutCycles(TO)
    ) u_fix (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(hreq), .host_we_i(hwe), .host_be_i(hbe),
        .host_addr_i(haddr), .host_wdata_i(hwd),
        .host_gnt_o(gnt_f), .host_rvalid_o(rv_f), .host_err_o(er_f),
        .host_rdata_o(rd_f),
        .device_req_o(dreq_f), .device_we_o(dwe_f), .device_be_o(dbe_f),
        .device_addr_o(dad_f), .device_wdata_o(dwd_f),
        .device_rvalid_i(drv_f), .device_err_i(der_f),
        .device_rdata_i(drd_f),
        .cfg_device_addr_base(cbase), .cfg_device_addr_mask(cmask),
        .timeout_o(to_f), .stray_o(st_f)
    );

    sim_bus_arb #(
        .NrHosts(NH), .NrDevices(ND), .DataWidth(32), .AddressWidth(32),
        .RoundRobin(1'b1), .TimeoutCycles(TO)
    ) u_rr (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(hreq), .host_we_i(hwe), .host_be_i(hbe),
        .host_addr_i(haddr), .host_wdata_i(hwd),
        .host_gnt_o(gnt_r), .host_rvalid_o(rv_r), .host_err_o(er_r),
        .host_rdata_o(rd_r),
        .device_req_o(dreq_r), .device_we_o(dwe_r), .device_be_o(dbe_r),
        .device_addr_o(dad_r), .device_wdata_o(dwd_r),
        .device_rvalid_i(drv_r), .device_err_i(der_r),
        .device_rdata_i(drd_r),
        .cfg_device_addr_base(cbase), .cfg_device_addr_mask(cmask),
        .timeout_o(to_r), .stray_o(st_r)
    );

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, want, cyc);
        end
    endtask

    function automatic snap_t get_snap(input int k);
        snap_t s;
        s = '0;
        if (k == 0) begin
            s.gnt = gnt_f; s.rv = rv_f; s.er = er_f;
            s.dreq = dreq_f; s.dwe = dwe_f; s.to = to_f; s.st = st_f;
            for (int h = 0; h < NH; h++) s.rd[h] = rd_f[h];
            for (int d = 0; d < ND; d++) begin
                s.dbe[d] = dbe_f[d]; s.dad[d] = dad_f[d]; s.dwd[d] = dwd_f[d];
            end
        end else begin
            s.gnt = gnt_r; s.rv = rv_r; s.er = er_r;
            s.dreq = dreq_r; s.dwe = dwe_r; s.to = to_r; s.st = st_r;
            for (int h = 0; h < NH; h++) s.rd[h] = rd_r[h];
            for (int d = 0; d < ND; d++) begin
                s.dbe[d] = dbe_r[d]; s.dad[d] = dad_r[d]; s.dwd[d] = dwd_r[d];
            end
        end
        return s;
    endfunction

    // Expected outputs from the bus rules: one transaction in flight,
    // identified by who owns it, which device owes it, and its age.
    task automatic model_eval(input int k, output snap_t e);
        logic [ND-1:0] rvv, erv;
        logic [31:0]   rdv [ND];
        bit owed, tmo;
        int h, w, t;
        e = '0;
        m_gnt[k] = 0; m_done[k] = 0; m_win[k] = 0; m_tgt[k] = -1;
        rvv = (k == 0) ? drv_f : drv_r;
        erv = (k == 0) ? der_f : der_r;
        for (int d = 0; d < ND; d++) rdv[d] = (k == 0) ? drd_f[d] : drd_r[d];
        if (rst) return;
        owed = (busy[k] == 1) && rvv[dv[k]];
        tmo  = (busy[k] == 1) && !owed && (age[k] == TO);
        m_done[k] = owed || tmo;
        for (int d = 0; d < ND; d++)
            if (rvv[d] && !(busy[k] == 1 && d == dv[k])) e.st = 1'b1;
        w = own[k];
        if (owed) begin
            e.rv[w] = 1'b1; e.er[w] = erv[dv[k]]; e.rd[w] = rdv[dv[k]];
        end else if (tmo) begin
            e.rv[w] = 1'b1; e.er[w] = 1'b1; e.to = 1'b1;
        end else if (busy[k] == 2) begin
            e.rv[w] = 1'b1; e.er[w] = 1'b1;
        end
        if (busy[k] != 1 || owed) begin
            for (int i = 0; i < NH; i++) begin
                h = (k == 1) ? (rrp[k] + i) % NH : i;
                if (!m_gnt[k] && hreq[h]) begin
                    m_gnt[k] = 1; m_win[k] = h;
                end
            end
        end
        if (m_gnt[k]) begin
            w = m_win[k];
            e.gnt[w] = 1'b1;
            for (int d = ND - 1; d >= 0; d--)
                if ((haddr[w] & cmask[d]) == cbase[d]) m_tgt[k] = d;
            t = m_tgt[k];
            if (t >= 0) begin
                e.dreq[t] = 1'b1; e.dwe[t] = hwe[w]; e.dbe[t] = hbe[w];
                e.dad[t] = haddr[w]; e.dwd[t] = hwd[w];
            end
        end
    endtask

    task automatic model_step(input int k);
        if (rst) begin
            busy[k] = 0; own[k] = 0; rrp[k] = 0; age[k] = 0; dv[k] = 0;
            return;
        end
        if (busy[k] == 1) begin
            if (m_done[k]) busy[k] = 0;
            else age[k]++;
        end else if (busy[k] == 2) begin
            busy[k] = 0;
        end
        if (m_gnt[k]) begin
            own[k]  = m_win[k];
            rrp[k]  = (m_win[k] + 1) % NH;
            busy[k] = (m_tgt[k] >= 0) ? 1 : 2;
            dv[k]   = (m_tgt[k] >= 0) ? m_tgt[k] : 0;
            age[k]  = 1;
        end
    endtask

    task automatic compare(input int k, input snap_t a, input snap_t e);
        string p;
        p = (k == 0) ? "fix" : "rr";
        chk({p, " gnt"},    128'(a.gnt),  128'(e.gnt));
        chk({p, " rvalid"}, 128'(a.rv),   128'(e.rv));
        chk({p, " err"},    128'(a.er),   128'(e.er));
        chk({p, " rdata"},  128'(a.rd),   128'(e.rd));
        chk({p, " dreq"},   128'(a.dreq), 128'(e.dreq));
        chk({p, " dwe"},    128'(a.dwe),  128'(e.dwe));
        chk({p, " dbe"},    128'(a.dbe),  128'(e.dbe));
        chk({p, " daddr"},  128'(a.dad),  128'(e.dad));
        chk({p, " dwdata"}, 128'(a.dwd),  128'(e.dwd));
        chk({p, " timeout"},128'(a.to),   128'(e.to));
        chk({p, " stray"},  128'(a.st),   128'(e.st));
    endtask

    // Device 0 is a RAM answering one cycle after each request.
    task automatic ram_react(input int k);
        int idx;
        pend_rv[k] = 0;
        pend_rd[k] = '0;
        if (!rst && last[k].dreq[0]) begin
            idx = int'(last[k].dad[0][9:2]);
            pend_rv[k] = 1;
            if (last[k].dwe[0]) begin
                for (int b = 0; b < 4; b++)
                    if (last[k].dbe[0][b])
                        ram[k][idx][8*b +: 8] = last[k].dwd[0][8*b +: 8];
            end else begin
                pend_rd[k] = ram[k][idx];
            end
        end
    endtask

    task automatic cycle();
        snap_t e;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            model_eval(k, e);
            last[k] = get_snap(k);
            compare(k, last[k], e);
            model_step(k);
            ram_react(k);
        end
        @(posedge clk);
        #1;
        drv_f = {1'b0, pend_rv[0]};
        drv_r = {1'b0, pend_rv[1]};
        drd_f[0] = pend_rd[0];
        drd_r[0] = pend_rd[1];
        cyc++;
    endtask

    task automatic host(input int h, input logic [31:0] addr,
                        input logic we, input logic [31:0] wd);
        hreq[h] = 1'b1; hwe[h] = we; haddr[h] = addr;
        hwd[h] = wd; hbe[h] = 4'hF;
    endtask

    task automatic idle_all();
        hreq = '0;
        hwe  = '0;
        for (int h = 0; h < NH; h++) begin
            haddr[h] = '0; hwd[h] = '0; hbe[h] = '0;
        end
    endtask

    task automatic kick();
        drv_f[1] = 1'b1;
        drv_r[1] = 1'b1;
    endtask

    initial begin
        int g0, g2, r2;
        logic [2:0] one;
        rst = 1'b1;
        idle_all();
        cbase[0] = 32'h0000_0000; cmask[0] = 32'hFFFF_0000;
        cbase[1] = 32'h0001_0000; cmask[1] = 32'hFFFF_0000;
        drv_f = '0; drv_r = '0; der_f = '0; der_r = '0;
        drd_f[0] = '0; drd_r[0] = '0;
        drd_f[1] = 32'h1111_1111; drd_r[1] = 32'h1111_1111;
        for (int k = 0; k < 2; k++) begin
            busy[k] = 0; own[k] = 0; dv[k] = 0; age[k] = 0; rrp[k] = 0;
            pend_rv[k] = 0; pend_rd[k] = '0;
            for (int i = 0; i < 256; i++) ram[k][i] = 32'hA500_0000 | 32'(i);
        end
        for (int h = 0; h < NH; h++) host(h, 32'h100, 1'b0, '0);
        cycle();
        chk("reset gnt fix", 128'(last[0].gnt), 128'(0));
        chk("reset gnt rr", 128'(last[1].gnt), 128'(0));
        rst = 1'b0;
        idle_all();
        cycle();

        // Hosts 0 and 2 hammer the RAM.
        g0 = 0; g2 = 0; r2 = 0;
        host(0, 32'h100, 1'b0, '0);
        host(2, 32'h100, 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            g0 += int'(last[0].gnt[0]);
            g2 += int'(last[0].gnt[2]);
            r2 += int'(last[1].gnt[2]);
            if (i > 0) chk("fix b2b rvalid", 128'(last[0].rv), 128'(3'b001));
        end
        chk("fix host0 grants", 128'(g0), 128'(6));
        chk("fix host2 starves", 128'(g2), 128'(0));
        chk("rr host2 grants", 128'(r2), 128'(3));
        idle_all();
        cycle();

        // All hosts request continuously.
        for (int h = 0; h < NH; h++) host(h, 32'h100, 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            one = 3'b001;
            chk("rr order", 128'(last[1].gnt), 128'(one << (i % 3)));
        end
        idle_all();
        cycle();

        // Unmapped address.
        host(1, 32'h0003_0000, 1'b0, '0);
        cycle();
        chk("derr gnt", 128'(last[0].gnt), 128'(3'b010));
        chk("derr no dreq", 128'(last[0].dreq), 128'(0));
        idle_all();
        cycle();
        chk("derr rvalid", 128'(last[0].rv), 128'(3'b010));
        chk("derr err", 128'(last[0].er), 128'(3'b010));
        chk("derr rdata", 128'(last[0].rd[1]), 128'(0));

        // Silent device: timeout, then a late stray response.
        host(0, 32'h0001_0000, 1'b0, '0);
        cycle();
        idle_all();
        for (int i = 1; i < TO; i++) cycle();
        chk("pre-timeout quiet", 128'(last[0].rv), 128'(0));
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("timeout rvalid", 128'(last[k].rv), 128'(3'b001));
            chk("timeout err", 128'(last[k].er), 128'(3'b001));
            chk("timeout pulse", 128'(last[k].to), 128'(1));
        end
        for (int i = TO + 1; i < 20; i++) cycle();
        kick();
        cycle();
        chk("late stray", 128'(last[0].st), 128'(1));
        chk("late no rvalid", 128'(last[0].rv), 128'(0));

        // Write then read pipelined in the write-response cycle.
        host(0, 32'h40, 1'b1, 32'hDEAD_BEEF);
        cycle();
        host(0, 32'h40, 1'b0, '0);
        cycle();
        chk("wr resp + rd gnt", 128'({last[0].rv, last[0].gnt}),
            128'(6'b001_001));
        idle_all();
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("read back", 128'(last[k].rd[0]), 128'(32'hDEAD_BEEF));
            chk("read err", 128'(last[k].er), 128'(0));
        end

        // Reset while a transaction is outstanding.
        host(1, 32'h0001_0000, 1'b0, '0);
        cycle();
        idle_all();
        cycle();
        rst = 1'b1;
        for (int h = 0; h < NH; h++) host(h, 32'h100, 1'b0, '0);
        cycle();
        for (int k = 0; k < 2; k++)
            chk("reset quiet", 128'({last[k].gnt, last[k].rv, last[k].er,
                last[k].dreq, last[k].to, last[k].st}), 128'(0));
        rst = 1'b0;
        kick();
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("post-reset stray", 128'(last[k].st), 128'(1));
            chk("post-reset gnt", 128'(last[k].gnt), 128'(3'b001));
        end
        idle_all();
        cycle();
        cycle();

        // Owed rvalid lands on the timeout cycle: response wins.
        host(2, 32'h0001_0000, 1'b0, '0);
        cycle();
        idle_all();
        for (int i = 1; i < TO; i++) cycle();
        kick();
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("race rvalid", 128'(last[k].rv), 128'(3'b100));
            chk("race no timeout", 128'(last[k].to), 128'(0));
            chk("race rdata", 128'(last[k].rd[2]), 128'(32'h1111_1111));
        end
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
